// File: rtl/nv_blkbox_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nv_blkbox_sink_pkg
// Brief    : Shared types, default constants and helpers for the blackbox
//            sink MISR (state encoding, default polynomial/seed, rotate-left).
// Revision : 1.0 - initial release
// ============================================================================
package nv_blkbox_sink_pkg;

    // Capture FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sink_state_e;

    // Default MISR feedback polynomial (CRC-32) and post-reset signature
    localparam logic [31:0] c_def_poly = 32'h04C11DB7;
    localparam logic [31:0] c_def_seed = 32'h0000_0000;

    // Working width of rotl; signatures up to this many bits are supported
    localparam int c_rot_w = 512;

    // Rotate the low 'width' bits of val left by amt (amt < width).
    // Bits above 'width' must be zero on input and are zero on output.
    function automatic logic [c_rot_w-1:0] rotl(
        input logic [c_rot_w-1:0] val,
        input int                 width,
        input int                 amt
    );
        logic [c_rot_w-1:0] mask;
        mask = ~({c_rot_w{1'b1}} << width);
        return ((val << amt) | (val >> (width - amt))) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nv_blkbox_sink_fold.sv
`default_nettype none
// ============================================================================
// Module   : nv_blkbox_sink_fold
// Brief    : Combinational XOR-fold of a DW-bit bus into SIG_W bits. The bus
//            is split into SIG_W-bit chunks, the last one zero-padded.
// Revision : 1.0 - initial release
// ============================================================================
module nv_blkbox_sink_fold #(
    parameter int DW    = 32,
    parameter int SIG_W = 32
) (
    input  logic [DW-1:0]    i_din,
    output logic [SIG_W-1:0] o_fold
);

    localparam int c_nchunk = (DW + SIG_W - 1) / SIG_W;
    localparam int c_pad_w  = c_nchunk * SIG_W;

    logic [c_pad_w-1:0] w_pad;

    assign w_pad = c_pad_w'(i_din);

    // XOR all SIG_W-bit chunks of the zero-padded bus together
    always_comb begin
        o_fold = '0;
        for (int k = 0; k < c_nchunk; k++) begin
            o_fold = o_fold ^ w_pad[k*SIG_W +: SIG_W];
        end
    end

endmodule
`default_nettype wire

// File: rtl/nv_blkbox_sink_misr.sv
`default_nettype none
// ============================================================================
// Module   : nv_blkbox_sink_misr
// Brief    : Multi-channel blackbox sink. Keeps CH x DW input buses alive and
//            compresses them into a SIG_W-bit MISR signature over a fixed or
//            open-ended window; the result is read out via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module nv_blkbox_sink_misr
    import nv_blkbox_sink_pkg::*;
#(
    parameter int               CH    = 4,
    parameter int               DW    = 32,
    parameter int               SIG_W = 32,
    parameter logic [31:0]      POLY  = c_def_poly,
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(c_def_seed)
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             sink_start,
    input  logic             sink_stop,
    input  logic             sink_clr,
    input  logic [15:0]      win_len,
    input  logic [CH-1:0]    ch_vld,
    input  logic [CH*DW-1:0] ch_dat,
    output logic [CH-1:0]    tie_out,
    output logic             busy,
    output logic             sig_vld,
    input  logic             sig_rdy,
    output logic [SIG_W-1:0] sig_dat,
    output logic [15:0]      sig_cnt
);

    localparam logic [SIG_W-1:0] c_poly = SIG_W'(POLY);

    sink_state_e      r_state;
    sink_state_e      w_state_nxt;
    logic [15:0]      r_cyc;
    logic [15:0]      w_cyc_inc;
    logic [15:0]      r_cnt;
    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_rot [CH];
    logic [SIG_W-1:0] w_in_word;
    logic             w_any_vld;
    logic             w_win_end;
    logic             w_entry;

    // Per-channel fold followed by a fixed rotation of (channel index mod SIG_W)
    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            logic [SIG_W-1:0] w_fold;

            nv_blkbox_sink_fold #(
                .DW    (DW),
                .SIG_W (SIG_W)
            ) u_fold (
                .i_din  (ch_dat[i*DW +: DW]),
                .o_fold (w_fold)
            );

            assign w_rot[i] = SIG_W'(rotl(c_rot_w'(w_fold), SIG_W, i % SIG_W));
        end
    endgenerate

    // Combine the rotated folds of all valid channels into one input word
    always_comb begin
        w_in_word = '0;
        for (int i = 0; i < CH; i++) begin
            if (ch_vld[i]) begin
                w_in_word = w_in_word ^ w_rot[i];
            end
        end
    end

    assign w_any_vld = |ch_vld;
    assign w_cyc_inc = r_cyc + 16'd1;
    // Fixed windows end on their win_len-th RUN cycle; open ones on sink_stop
    assign w_win_end = (r_state == ST_RUN) &&
                       ((win_len != 16'd0) ? (w_cyc_inc == win_len) : sink_stop);
    assign w_entry   = (r_state == ST_IDLE) && sink_start;

    // State register
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clear overrides every other request
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (sink_start)        w_state_nxt = ST_RUN;
            ST_RUN:  if (w_win_end)         w_state_nxt = ST_DONE;
            ST_DONE: if (sig_rdy)           w_state_nxt = ST_IDLE;
            default:                        w_state_nxt = ST_IDLE;
        endcase
        if (sink_clr) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Signature, sample counter and window cycle counter
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_sig <= SEED;
            r_cnt <= 16'd0;
            r_cyc <= 16'd0;
        end else if (sink_clr || w_entry) begin
            r_sig <= SEED;
            r_cnt <= 16'd0;
            r_cyc <= 16'd0;
        end else if (r_state == ST_RUN) begin
            r_cyc <= w_cyc_inc;
            if (w_any_vld) begin
                r_sig <= (r_sig << 1) ^ (r_sig[SIG_W-1] ? c_poly : '0) ^ w_in_word;
                if (r_cnt != 16'hFFFF) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end
    end

    assign tie_out = '0;
    assign busy    = (r_state == ST_RUN);
    assign sig_vld = (r_state == ST_DONE);
    assign sig_dat = r_sig;
    assign sig_cnt = r_cnt;

endmodule
`default_nettype wire
